sentinel_mtimer: RTL and testbench



---
 rtl/sentinel_mtimer.sv | 181 ++++++++++++++++++
 tb/tb_sentinel_mtimer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sentinel_mtimer.sv
// sentinel_mtimer: machine timer on the Wishbone classic data bus.
// Holds a free-running 64-bit mtime and a 64-bit mtimecmp, word addressed
// (0/1 = mtime lo/hi, 2/3 = mtimecmp lo/hi). irq is a registered mtime >= mtimecmp.
// Every access is acknowledged WAIT_STATES+1 cycles after the request is first seen.
// Optional feature macro MTIMER_SNAPSHOT_EN: a read of address 0 latches mtime[63:32]
// into a shadow that a following read of address 1 returns (tear-free 64-bit read).
module sentinel_mtimer #(
  parameter int WAIT_STATES = 0,
  parameter int PRESCALE    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus__cyc,
  input  logic        bus__stb,
  input  logic        bus__we,
  input  logic [3:0]  bus__sel,
  input  logic [1:0]  bus__adr,
  input  logic [31:0] bus__dat_w,
  output logic [31:0] bus__dat_r,
  output logic        bus__ack,
  output logic        irq
);

  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  // The IDLE->WAIT edge already spends one of the wait cycles.
  localparam logic [1:0]      WS_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t          state, state_nxt;
  logic [1:0]      wcnt, wcnt_nxt;
  logic            req;
  logic            commit;
  logic            wr_en;
  logic            wr_lo, wr_hi, wr_clo, wr_chi;
  logic            tick;
  logic            carry;
  logic [PS_W-1:0] pcnt;
  logic [63:0]     mtime;
  logic [63:0]     mtimecmp;
  logic [31:0]     mtime_lo_nxt;
  logic [31:0]     mtime_hi_nxt;
  logic [31:0]     rd_val;
`ifdef MTIMER_SNAPSHOT_EN
  logic [31:0]     shadow_hi;
`endif

  // Replace only the byte lanes enabled in sel.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  assign req      = bus__cyc && bus__stb;
  assign bus__ack = (state == ACK);
  assign tick     = (pcnt == PS_LAST);

  // A write takes effect only on the edge entering ACK and only with some byte selected.
  assign wr_en  = commit && bus__we && (bus__sel != 4'b0000);
  assign wr_lo  = wr_en && (bus__adr == 2'd0);
  assign wr_hi  = wr_en && (bus__adr == 2'd1);
  assign wr_clo = wr_en && (bus__adr == 2'd2);
  assign wr_chi = wr_en && (bus__adr == 2'd3);

  // A carry into the high half is dropped when the low half is overwritten this edge.
  assign carry = tick && (mtime[31:0] == 32'hFFFF_FFFF) && !wr_lo;

  // Bus FSM next state: count wait cycles, abort on a dropped request, single-cycle ACK.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_nxt = ACK;
            commit    = 1'b1;
          end else begin
            state_nxt = WAIT;
            wcnt_nxt  = WS_LOAD;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_nxt = IDLE;
        end else if (wcnt == 2'd0) begin
          state_nxt = ACK;
          commit    = 1'b1;
        end else begin
          wcnt_nxt = wcnt - 2'd1;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus FSM state and wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wcnt  <= 2'd0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Next mtime halves: a write wins over the tick on its own half only.
  always_comb begin
    mtime_lo_nxt = mtime[31:0];
    mtime_hi_nxt = mtime[63:32];
    if (wr_lo)     mtime_lo_nxt = merge_bytes(mtime[31:0], bus__dat_w, bus__sel);
    else if (tick) mtime_lo_nxt = mtime[31:0] + 32'd1;
    if (wr_hi)      mtime_hi_nxt = merge_bytes(mtime[63:32], bus__dat_w, bus__sel);
    else if (carry) mtime_hi_nxt = mtime[63:32] + 32'd1;
  end

  // Read mux over the pre-edge register values.
  always_comb begin
    rd_val = 32'd0;
    unique case (bus__adr)
      2'd0: rd_val = mtime[31:0];
`ifdef MTIMER_SNAPSHOT_EN
      2'd1: rd_val = shadow_hi;
`else
      2'd1: rd_val = mtime[63:32];
`endif
      2'd2: rd_val = mtimecmp[31:0];
      2'd3: rd_val = mtimecmp[63:32];
      default: rd_val = 32'd0;
    endcase
  end

  // Prescaler: tick on PRESCALE-1, then wrap to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pcnt <= '0;
    else        pcnt <= tick ? '0 : pcnt + PS_W'(1);
  end

  // Timer and compare registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime    <= 64'd0;
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      mtime <= {mtime_hi_nxt, mtime_lo_nxt};
      if (wr_clo) mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], bus__dat_w, bus__sel);
      if (wr_chi) mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], bus__dat_w, bus__sel);
    end
  end

  // Read data is held only for the ACK cycle of a read, zero otherwise; irq is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus__dat_r <= 32'd0;
      irq        <= 1'b0;
    end else begin
      bus__dat_r <= (commit && !bus__we) ? rd_val : 32'd0;
      irq        <= (mtime >= mtimecmp);
    end
  end

`ifdef MTIMER_SNAPSHOT_EN
  // Capture the high half alongside every low-half read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        shadow_hi <= 32'd0;
    else if (commit && !bus__we && bus__adr == 2'd0)   shadow_hi <= mtime[63:32];
  end
`endif

endmodule

// File: tb/tb_sentinel_mtimer.sv
// Testbench for sentinel_mtimer (WAIT_STATES=2, PRESCALE=1): randomized and directed
// bus traffic against a transaction-level reference model, plus literal expectations.
module tb_sentinel_mtimer;

  localparam int WS = 2;
  localparam int PS = 1;

  logic        clk;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [1:0]  adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;
  logic        irq;

  sentinel_mtimer #(.WAIT_STATES(WS), .PRESCALE(PS)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus__cyc   (cyc),
    .bus__stb   (stb),
    .bus__we    (we),
    .bus__sel   (sel),
    .bus__adr   (adr),
    .bus__dat_w (dat_w),
    .bus__dat_r (dat_r),
    .bus__ack   (ack),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  bit chk_en;
  bit irq_at_ack;
  logic [31:0] rd;
  int lat;
  int n;
  int kind;
  bit got;

  // Reference model state
  logic [63:0] m_time, m_cmp;
  logic [31:0] m_dat, m_shadow;
  bit          m_ack, m_irq;
  int          m_age, m_pc;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (d & m);
  endfunction

  task automatic model_reset();
    m_time = 64'd0; m_cmp = '1; m_dat = 32'd0; m_shadow = 32'd0;
    m_ack = 1'b0; m_irq = 1'b0; m_age = 0; m_pc = 0;
  endtask

  // One clock edge of the peripheral, from the specification's rules.
  task automatic model_step();
    bit tick, commit;
    logic [63:0] t;
    tick   = (m_pc == PS - 1);
    commit = 1'b0;
    if (m_ack) m_age = 0;
    else if (cyc && stb) begin
      m_age++;
      if (m_age == WS + 1) begin commit = 1'b1; m_age = 0; end
    end else m_age = 0;
    m_irq = (m_time >= m_cmp);
    t = tick ? m_time + 64'd1 : m_time;
    m_dat = 32'd0;
    if (commit && !we) begin
      case (adr)
        2'd0: m_dat = m_time[31:0];
`ifdef MTIMER_SNAPSHOT_EN
        2'd1: m_dat = m_shadow;
`else
        2'd1: m_dat = m_time[63:32];
`endif
        2'd2: m_dat = m_cmp[31:0];
        default: m_dat = m_cmp[63:32];
      endcase
`ifdef MTIMER_SNAPSHOT_EN
      if (adr == 2'd0) m_shadow = m_time[63:32];
`endif
    end
    if (commit && we && sel != 4'b0) begin
      case (adr)
        2'd0: t = {m_time[63:32], bmerge(m_time[31:0], dat_w, sel)};
        2'd1: t = {bmerge(m_time[63:32], dat_w, sel), t[31:0]};
        2'd2: m_cmp[31:0]  = bmerge(m_cmp[31:0], dat_w, sel);
        default: m_cmp[63:32] = bmerge(m_cmp[63:32], dat_w, sel);
      endcase
    end
    m_time = t;
    m_ack  = commit;
    m_pc   = tick ? 0 : m_pc + 1;
  endtask

  task automatic bus_xfer(input logic w, input logic [1:0] a, input logic [3:0] s,
                          input logic [31:0] d, output logic [31:0] rdv, output int lt);
    bit ok;
    ok = 1'b0; rdv = 32'd0; lt = 0;
    @(posedge clk); #2;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_w = d;
    while (!ok && lt < 10) begin
      @(negedge clk); lt++;
      if (ack) begin ok = 1'b1; rdv = dat_r; irq_at_ack = irq; end
    end
    chk("xfer_ack_seen", 64'(ok), 64'd1);
    @(posedge clk); #2;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic bus_abort(input logic w, input logic [1:0] a, input logic [3:0] s,
                           input logic [31:0] d, input int stay, input bit drop_cyc);
    @(posedge clk); #2;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_w = d;
    repeat (stay + 1) begin @(posedge clk); #2; end
    if (drop_cyc) cyc = 1'b0; else stb = 1'b0;
    @(posedge clk); #2;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; chk_en = 1'b0; irq_at_ack = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'b0; adr = 2'b0; dat_w = 32'd0;
    rst_n = 1'b0;
    model_reset();
    fork
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else        model_step();
      end
      forever begin
        @(negedge clk);
        if (chk_en) begin
          chk("ack", 64'(ack), 64'(m_ack));
          chk("dat_r", 64'(dat_r), 64'(m_dat));
          chk("irq", 64'(irq), 64'(m_irq));
        end
      end
    join_none

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_irq", 64'(irq), 64'd0);
    chk("reset_ack", 64'(ack), 64'd0);
    chk("reset_dat_r", 64'(dat_r), 64'd0);
    bus_xfer(1'b0, 2'd0, 4'hF, 32'd0, rd, lat);
    chk("reset_mtime_small", 64'(rd < 32'd16), 64'd1);

    // Latency with two wait states; ack for one cycle only
    bus_xfer(1'b0, 2'd3, 4'hF, 32'd0, rd, lat);
    chk("cmp_hi_reset", 64'(rd), 64'hFFFF_FFFF);
    chk("ack_latency", 64'(lat), 64'd4);
    @(negedge clk);
    chk("ack_one_cycle", 64'(ack), 64'd0);

    // Partial write
    bus_xfer(1'b1, 2'd2, 4'b0011, 32'h1234_5678, rd, lat);
    bus_xfer(1'b0, 2'd2, 4'hF, 32'd0, rd, lat);
    chk("partial_write", 64'(rd), 64'hFFFF_5678);

    // Compare and interrupt: mtimecmp = 5, restart mtime at 0
    bus_xfer(1'b1, 2'd2, 4'hF, 32'd5, rd, lat);
    bus_xfer(1'b1, 2'd3, 4'hF, 32'd0, rd, lat);
    bus_xfer(1'b1, 2'd0, 4'hF, 32'd0, rd, lat);
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk); n++;
      if (irq) got = 1'b1;
    end
    chk("irq_rise_cycle", 64'(n), 64'd6);
    bus_xfer(1'b1, 2'd3, 4'hF, 32'd1, rd, lat);
    chk("irq_high_at_ack", 64'(irq_at_ack), 64'd1);
    @(negedge clk);
    chk("irq_fall_after_ack", 64'(irq), 64'd0);

    // Wrap through 2^64
    bus_xfer(1'b1, 2'd1, 4'hF, 32'hFFFF_FFFF, rd, lat);
    bus_xfer(1'b1, 2'd0, 4'hF, 32'hFFFF_FFFE, rd, lat);
    bus_xfer(1'b0, 2'd1, 4'hF, 32'd0, rd, lat);
    chk("wrap_hi", 64'(rd), 64'd0);
    bus_xfer(1'b0, 2'd0, 4'hF, 32'd0, rd, lat);
    chk("wrap_lo", 64'(rd), 64'd7);

    // Low-half write on the edge whose tick would carry out of the low half
    bus_xfer(1'b1, 2'd1, 4'hF, 32'd7, rd, lat);
    bus_xfer(1'b1, 2'd0, 4'hF, 32'hFFFF_FFFB, rd, lat);
    bus_xfer(1'b1, 2'd0, 4'hF, 32'h0000_0010, rd, lat);
    bus_xfer(1'b0, 2'd1, 4'hF, 32'd0, rd, lat);
    chk("collision_hi", 64'(rd), 64'd7);
    bus_xfer(1'b0, 2'd0, 4'hF, 32'd0, rd, lat);
    chk("collision_lo", 64'(rd), 64'h19);

    // Aborted accesses leave registers untouched
    bus_abort(1'b1, 2'd2, 4'hF, 32'hDEAD_BEEF, 0, 1'b0);
    bus_abort(1'b1, 2'd3, 4'hF, 32'hCAFE_F00D, 1, 1'b1);
    bus_xfer(1'b0, 2'd2, 4'hF, 32'd0, rd, lat);
    chk("abort_cmp_lo", 64'(rd), 64'd5);
    bus_xfer(1'b0, 2'd3, 4'hF, 32'd0, rd, lat);
    chk("abort_cmp_hi", 64'(rd), 64'd1);

    // Low read at 0x0000_0000_FFFF_FFFF, then high read after the carry
    bus_xfer(1'b1, 2'd1, 4'hF, 32'd0, rd, lat);
    bus_xfer(1'b1, 2'd0, 4'hF, 32'hFFFF_FFFB, rd, lat);
    bus_xfer(1'b0, 2'd0, 4'hF, 32'd0, rd, lat);
    chk("snap_lo", 64'(rd), 64'hFFFF_FFFF);
    bus_xfer(1'b0, 2'd1, 4'hF, 32'd0, rd, lat);
`ifdef MTIMER_SNAPSHOT_EN
    chk("snap_hi_shadow", 64'(rd), 64'd0);
`else
    chk("snap_hi_live", 64'(rd), 64'd1);
`endif

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0)
        bus_abort(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom),
                  $urandom, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else if (kind == 1)
        repeat ($urandom_range(1, 4)) @(posedge clk);
      else
        bus_xfer(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom),
                 ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 200)), rd, lat);
    end

    // Reset during an ACK cycle with irq high
    bus_xfer(1'b1, 2'd3, 4'hF, 32'd0, rd, lat);
    bus_xfer(1'b1, 2'd2, 4'hF, 32'd0, rd, lat);
    @(posedge clk); #2;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd0; sel = 4'hF;
    n = 0; got = 1'b0;
    while (!got && n < 10) begin
      @(negedge clk); n++;
      if (ack) got = 1'b1;
    end
    chk("midreset_ack_seen", 64'(got), 64'd1);
    chk("midreset_irq_before", 64'(irq), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_ack", 64'(ack), 64'd0);
    chk("midreset_dat_r", 64'(dat_r), 64'd0);
    chk("midreset_irq", 64'(irq), 64'd0);
    cyc = 1'b0; stb = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    bus_xfer(1'b0, 2'd3, 4'hF, 32'd0, rd, lat);
    chk("post_reset_cmp_hi", 64'(rd), 64'hFFFF_FFFF);
    bus_xfer(1'b0, 2'd0, 4'hF, 32'd0, rd, lat);
    chk("post_reset_mtime_small", 64'(rd < 32'd16), 64'd1);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
